// File: rtl/uart_rx_pkg.sv
// UART receive shared definitions: FSM encoding, prescale and parity constants.
// Imported by the frame controller and its edge/bit counter.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [7:0] PRESC_8   = 8'd8;
  localparam logic [7:0] PRESC_16  = 8'd16;
  localparam logic [7:0] PRESC_32  = 8'd32;
  localparam logic [7:0] PRESC_DEF = PRESC_8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Last edge index of a bit; anything not legal behaves as the default.
  function automatic logic [4:0] presc_pm1(input logic [7:0] p);
    logic [4:0] r;
    case (p)
      PRESC_16: r = 5'd15;
      PRESC_32: r = 5'd31;
      default:  r = 5'd7;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter.
// Flags the last edge of each bit and the last data bit.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int EDGE_W     = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [EDGE_W-1:0] pm1_i,
  output logic [EDGE_W-1:0] edge_cnt_o,
  output logic              wrap_o,
  output logic              data_done_o
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 4);

  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  assign edge_cnt_o  = edge_q;
  assign wrap_o      = run_i && (edge_q == pm1_i);
  assign data_done_o = wrap_o && (bit_q == BIT_W'(DATA_WIDTH));

  // Detection cycle is edge 0, so a new frame resumes at edge 1.
  always_comb begin
    edge_d = '0;
    bit_d  = '0;
    if (start_i) begin
      edge_d = EDGE_W'(1);
    end else if (run_i) begin
      if (wrap_o) begin
        bit_d = bit_q + BIT_W'(1);
      end else begin
        edge_d = edge_q + EDGE_W'(1);
        bit_d  = bit_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, sampler enable,
// LSB-first deserialiser, parity/stop checks and data_valid strobe.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [7:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  logic [2:0]            state_q, state_d;
  logic [EDGE_W-1:0]     pm1_q, s_edge;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  en_q, dv_q, par_err_q, stp_err_q;
  logic                  start_det, samp, abort, run;
  logic                  wrap, data_done, exp_par;

  assign s_edge    = (pm1_q >> 1) + EDGE_W'(2);
  assign start_det = (state_q == ST_IDLE) && !RX_IN;
  assign samp      = (state_q != ST_IDLE) && (edge_cnt == s_edge);
  assign abort     = (state_q == ST_START) && samp && sampled_bit;
  assign run       = (state_q != ST_IDLE) && !abort;
  assign exp_par   = (^data_q) ^ (PAR_TYP == PAR_ODD);

  uart_rx_edge_bit_cnt #(
    .EDGE_W    (EDGE_W),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_det),
    .run_i      (run),
    .pm1_i      (pm1_q),
    .edge_cnt_o (edge_cnt),
    .wrap_o     (wrap),
    .data_done_o(data_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_det) state_d = ST_START;
      ST_START: begin
        if (abort)     state_d = ST_IDLE;
        else if (wrap) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (data_done) state_d = PAR_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (wrap) state_d = ST_STOP;
      ST_STOP:   if (wrap) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pm1_q     <= EDGE_W'(presc_pm1(PRESC_DEF));
      data_q    <= '0;
      en_q      <= 1'b0;
      dv_q      <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d != ST_IDLE);
      // Strobe lands on edge S+1, after the stop sample.
      dv_q    <= (state_q == ST_STOP) && samp && sampled_bit && !par_err_q;
      if (start_det) begin
        pm1_q     <= EDGE_W'(presc_pm1(prescale));
        par_err_q <= 1'b0;
        stp_err_q <= 1'b0;
      end
      if (state_q == ST_DATA && samp)
        data_q <= {sampled_bit, data_q[DATA_WIDTH-1:1]};
      if (state_q == ST_PARITY && samp)
        par_err_q <= sampled_bit ^ exp_par;
      if (state_q == ST_STOP && samp)
        stp_err_q <= ~sampled_bit;
    end
  end

  assign dat_samp_en = en_q;
  assign P_DATA      = data_q;
  assign data_valid  = dv_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl with an ideal line sampler.
// Accepted frames are queued at stimulus time and matched on data_valid.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b1;
  logic [7:0] prescale = 8'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [4:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   dv_prev = 1'b0;

  assign sampled_bit = RX_IN;

  uart_rx_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .sampled_bit(sampled_bit),
    .dat_samp_en(dat_samp_en),
    .edge_cnt   (edge_cnt),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dv_prev) chk("dv_width", data_valid, 0);
    dv_prev = data_valid && rst;
    if (rst && data_valid) begin
      chk("dv_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("p_data", P_DATA, e.d);
        chk("dv_cycle", cyc, e.cyc);
        chk("dv_par_err", par_err, 0);
        chk("dv_stp_err", stp_err, 0);
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the current cycle becomes edge 0.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] pdrv,
                            input int plen, input logic pen,
                            input logic ptyp, input logic pflip,
                            input logic stopb, input bit chg,
                            input bit ok);
    exp_t e;
    int   nb;
    prescale = pdrv;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    nb = pen ? 11 : 10;
    if (ok) begin
      e.d   = d;
      e.cyc = cyc + (nb - 1) * plen + plen / 2 + 2;
      exp_q.push_back(e);
    end
    drive_bit(1'b0, plen);
    for (int i = 0; i < 8; i++) begin
      if (chg && i == 3) prescale = 8'd8;
      drive_bit(d[i], plen);
    end
    if (pen) drive_bit((^d) ^ ptyp ^ pflip, plen);
    drive_bit(stopb, plen);
    RX_IN = 1'b1;
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", dat_samp_en, 0);
    chk("rst_edge", edge_cnt, 0);
    chk("rst_data", P_DATA, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_perr", par_err, 0);
    chk("rst_serr", stp_err, 0);
    rst = 1'b1;
    idle(3);

    send_frame(8'hA5, 8'd8, 8, 0, 0, 0, 1, 0, 1);
    chk("a5_perr", par_err, 0);
    chk("a5_serr", stp_err, 0);

    send_frame(8'h03, 8'd8, 8, 1, 0, 1, 1, 0, 0);
    chk("par_bad_perr", par_err, 1);
    chk("par_bad_serr", stp_err, 0);

    send_frame(8'h03, 8'd8, 8, 1, 0, 0, 1, 0, 1);
    chk("par_ok_perr", par_err, 0);

    send_frame(8'hA5, 8'd8, 8, 1, 1, 0, 1, 0, 1);
    chk("odd_ok_perr", par_err, 0);

    send_frame(8'h5A, 8'd16, 16, 0, 0, 0, 0, 0, 0);
    chk("stp_serr", stp_err, 1);
    chk("stp_perr", par_err, 0);
    chk("stp_idle", dat_samp_en, 0);
    chk("stp_data", P_DATA, 8'h5A);
    idle(3);

    send_frame(8'h3C, 8'd32, 32, 0, 0, 0, 1, 1, 1);
    idle(3);

    RX_IN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RX_IN = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("glitch_en_s", dat_samp_en, 1);
    @(negedge clk);
    chk("glitch_en_off", dat_samp_en, 0);
    chk("glitch_edge", edge_cnt, 0);
    chk("glitch_perr", par_err, 0);
    chk("glitch_serr", stp_err, 0);
    @(posedge clk);
    #1;
    idle(4);
    chk("glitch_stay", dat_samp_en, 0);

    send_frame(8'h11, 8'd32, 32, 0, 0, 0, 1, 0, 1);
    send_frame(8'hEE, 8'd32, 32, 0, 0, 0, 1, 0, 1);
    idle(2);

    send_frame(8'hC3, 8'd12, 8, 0, 0, 0, 1, 0, 1);
    idle(2);

    prescale = 8'd8;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 3);
    chk("pre_rst_en", dat_samp_en, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_en", dat_samp_en, 0);
    chk("mid_rst_edge", edge_cnt, 0);
    chk("mid_rst_data", P_DATA, 0);
    chk("mid_rst_dv", data_valid, 0);
    chk("mid_rst_flags", {par_err, stp_err}, 0);
    RX_IN = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);
    send_frame(8'h7E, 8'd8, 8, 0, 0, 0, 1, 0, 1);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- UART receive frame controller that sits directly upstream of the receive data sampler.
- Detects the start bit, runs the per-bit oversampling edge counter and bit counter, and asserts `dat_samp_en` for the sampler.
- Consumes the sampler's majority-voted `sampled_bit` and deserialises it LSB-first into a byte.
- Checks parity and stop bit, then raises a one-cycle `data_valid` strobe with error flags toward the command parser.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- EDGE_W, 5, edge counter width; supports prescale up to 32.

Ports:
- clk  in  1  receive oversampling clock.
- rst  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line; idle high; already synchronised.
- prescale  in  8  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  in  1  1 = parity bit present after data.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- sampled_bit  in  1  majority-voted bit from the sampler.
- dat_samp_en  out  1  enables the sampler.
- edge_cnt  out  EDGE_W  oversampling edge index within the current bit.
- P_DATA  out  DATA_WIDTH  received byte.
- data_valid  out  1  one-cycle strobe, frame accepted.
- par_err  out  1  parity mismatch in the last frame.
- stp_err  out  1  stop bit sampled as 0 in the last frame.

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE.
  - edge_cnt, bit counter, P_DATA, data_valid, par_err, stp_err and dat_samp_en all 0.
  - Reset mid-frame abandons the frame with no data_valid.
- Prescale latching:
  - prescale is latched on start detection; changes mid-frame are ignored.
  - A non-legal value is latched as 8.
  - Define P = latched prescale and S = P/2+1. S is the only edge at which sampled_bit is valid.
- States: IDLE, START, DATA, PARITY, STOP.
  - dat_samp_en = 1 in every state except IDLE; it is registered with the state.
- IDLE:
  - edge_cnt holds 0.
  - RX_IN=0 on a clock edge: the next cycle enters START with edge_cnt=1; the detection cycle counts as edge 0.
  - Entering START clears par_err and stp_err.
- Edge counter:
  - Increments each cycle outside IDLE and wraps from P-1 to 0.
  - On wrap the bit counter increments and the state advances.
- START:
  - At edge S, sampled_bit=1 is a glitch: return to IDLE on the next cycle. No flags change; dat_samp_en drops.
  - Otherwise, at the wrap, go to DATA.
- DATA:
  - At edge S, shift sampled_bit into P_DATA, LSB first (bit k of the frame lands in P_DATA[k]).
  - After DATA_WIDTH bits, at the wrap, go to PARITY if PAR_EN=1, else STOP.
- PARITY:
  - At edge S, set par_err = sampled_bit XOR expected parity.
  - Expected parity = XOR of P_DATA when PAR_TYP=0, XNOR when PAR_TYP=1.
  - At the wrap, go to STOP.
- STOP:
  - At edge S, set stp_err = ~sampled_bit.
  - data_valid = 1 for exactly one cycle, in the cycle with edge_cnt=S+1, only if stp_err=0 and par_err=0.
  - At edge P-1, return to IDLE; the next frame can be detected on the following cycle.
- Outputs:
  - P_DATA is updated only by shifting during DATA; it is stable from data_valid until the next frame's first data sample.
  - Error flags are held until the next start detection.
- Latency, 8N1 with P=8: data_valid is asserted 78 cycles after the detection cycle (bit 9, edge 6).
- Simultaneous events: RX_IN edges outside IDLE are ignored; only S-edge samples matter.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the state enumeration (3-bit encoding);
  - the legal prescale constants 8/16/32;
  - the default prescale;
  - the parity type constants.
- One sub-module, uart_rx_edge_bit_cnt, contains the edge counter, bit counter and wrap/bit-done flags, enabled by the FSM.
- The FSM, deserialiser and checkers live in the top module.

Test Plan:
- Frame 8N1, P=8, byte 0xA5, line-accurate model sampler → P_DATA=0xA5; data_valid exactly 1 cycle, 78 cycles after detection; par_err=0, stp_err=0.
- PAR_EN=1, PAR_TYP=0, byte 0x03, parity bit 1 (wrong) → par_err=1, no data_valid. Repeat with parity bit 0 → data_valid=1, par_err=0.
- P=16, byte 0x5A, stop bit driven 0 → stp_err=1, no data_valid; FSM back in IDLE after 160 cycles.
- RX_IN low for 2 cycles only, P=8 → sampled start=1, IDLE on the following cycle, dat_samp_en=0, no flags.
- Back-to-back frames 0x11 then 0xEE, P=32, no idle gap → two data_valid pulses 320 cycles apart with correct bytes. Also change prescale to 8 mid-frame → the current frame is still received at 32.
- Assert rst mid-DATA → all outputs 0 immediately; the next full frame 0x7E is received correctly.
